// File: rtl/pixie_dma_sequencer.sv
// DMA sequencer feeding the 1861 Pixie: takes the CDP1802 bus on DMA-out,
// fetches display bytes at the DMA pointer and strobes them out with mem_ack.
module pixie_dma_sequencer #(
    parameter int unsigned        ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]  START_ADDR = ADDR_W'(16'h0900),
    parameter int unsigned        BURST_MAX  = 8,
    parameter int unsigned        CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              dmao_n,
    input  logic              frame_int,
    input  logic [1:0]        cpu_sc,
    input  logic              cpu_hold_ack,
    input  logic              r0_load,
    input  logic [ADDR_W-1:0] r0_value,
    input  logic              bus_rdy,
    input  logic [7:0]        bus_data,
    output logic              cpu_hold,
    output logic [1:0]        SC,
    output logic              bus_rd,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        data_out,
    output logic              mem_ack,
    output logic [ADDR_W-1:0] dma_ptr,
    output logic              burst_done
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        DATA,
        RELEASE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   count, count_d, count_inc;
    logic               frame_q;
    logic               frame_rise;
    logic               hold_d, rd_d, ack_d, done_d;
    logic [ADDR_W-1:0]  addr_d, ptr_d;
    logic [7:0]         dout_d;

    assign count_inc  = count + CNT_W'(1);
    assign frame_rise = frame_int & ~frame_q;

    always_comb begin
        SC = cpu_sc;
        if (state == ADDR || state == DATA)
            SC = 2'b10;
    end

    always_comb begin
        state_d = state;
        count_d = count;
        hold_d  = cpu_hold;
        rd_d    = bus_rd;
        addr_d  = bus_addr;
        dout_d  = data_out;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        ptr_d   = dma_ptr;
        if (clk_enable) begin
            case (state)
                IDLE: begin
                    if (!dmao_n) begin
                        state_d = REQ;
                        hold_d  = 1'b1;
                    end
                end
                REQ: begin
                    // A withdrawn request before the CPU lets go returns the bus untouched
                    if (dmao_n)
                        state_d = RELEASE;
                    else if (cpu_hold_ack)
                        state_d = ADDR;
                end
                ADDR: begin
                    addr_d  = dma_ptr;
                    rd_d    = 1'b1;
                    state_d = DATA;
                end
                DATA: begin
                    if (bus_rdy) begin
                        dout_d  = bus_data;
                        ack_d   = 1'b1;
                        ptr_d   = dma_ptr + ADDR_W'(1);
                        count_d = count_inc;
                        rd_d    = 1'b0;
                        if (!dmao_n && (count_inc < CNT_W'(BURST_MAX)))
                            state_d = ADDR;
                        else
                            state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    hold_d  = 1'b0;
                    done_d  = 1'b1;
                    count_d = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        // Pointer reloads bypass clk_enable and override the DMA increment
        if (frame_rise)
            ptr_d = START_ADDR;
        if (r0_load)
            ptr_d = r0_value;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            cpu_hold   <= 1'b0;
            bus_rd     <= 1'b0;
            bus_addr   <= '0;
            data_out   <= '0;
            mem_ack    <= 1'b0;
            burst_done <= 1'b0;
            dma_ptr    <= START_ADDR;
            frame_q    <= 1'b0;
        end else begin
            state      <= state_d;
            count      <= count_d;
            cpu_hold   <= hold_d;
            bus_rd     <= rd_d;
            bus_addr   <= addr_d;
            data_out   <= dout_d;
            mem_ack    <= ack_d;
            burst_done <= done_d;
            dma_ptr    <= ptr_d;
            frame_q    <= frame_int;
        end
    end

endmodule

// File: tb/tb_pixie_dma_sequencer.sv
// Directed self-checking bench for pixie_dma_sequencer with a simple RAM model.
module tb_pixie_dma_sequencer;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        dmao_n;
    logic        frame_int;
    logic [1:0]  cpu_sc;
    logic        cpu_hold_ack;
    logic        r0_load;
    logic [15:0] r0_value;
    logic        bus_rdy;
    logic [7:0]  bus_data;
    logic        cpu_hold;
    logic [1:0]  SC;
    logic        bus_rd;
    logic [15:0] bus_addr;
    logic [7:0]  data_out;
    logic        mem_ack;
    logic [15:0] dma_ptr;
    logic        burst_done;

    int checks   = 0;
    int failures = 0;
    int acks, bds, scn, rds;
    logic rd_prev;
    logic [7:0]  dq[$];
    logic [15:0] aq[$];

    pixie_dma_sequencer #(
        .ADDR_W     (16),
        .START_ADDR (16'h0900),
        .BURST_MAX  (8),
        .CNT_W      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_enable   (clk_enable),
        .dmao_n       (dmao_n),
        .frame_int    (frame_int),
        .cpu_sc       (cpu_sc),
        .cpu_hold_ack (cpu_hold_ack),
        .r0_load      (r0_load),
        .r0_value     (r0_value),
        .bus_rdy      (bus_rdy),
        .bus_data     (bus_data),
        .cpu_hold     (cpu_hold),
        .SC           (SC),
        .bus_rd       (bus_rd),
        .bus_addr     (bus_addr),
        .data_out     (data_out),
        .mem_ack      (mem_ack),
        .dma_ptr      (dma_ptr),
        .burst_done   (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    always_comb bus_data = mem_byte(bus_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mem_ack) begin
            acks++;
            dq.push_back(data_out);
        end
        if (burst_done) bds++;
        if (SC == 2'b10) scn++;
        if (bus_rd && !rd_prev) begin
            rds++;
            aq.push_back(bus_addr);
        end
        rd_prev = bus_rd;
    endtask

    task automatic clear_counts();
        acks = 0; bds = 0; scn = 0; rds = 0;
        dq.delete();
        aq.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; dmao_n = 1'b1; r0_load = 1'b0; frame_int = 1'b0;
        clk_enable = 1'b1; cpu_hold_ack = 1'b1; bus_rdy = 1'b1; cpu_sc = 2'b01;
        tick();
        tick();
        reset = 1'b0;
        rd_prev = 1'b0;
        clear_counts();
    endtask

    task automatic load_r0(input logic [15:0] v);
        r0_load = 1'b1; r0_value = v;
        tick();
        r0_load = 1'b0;
    endtask

    initial begin
        r0_value = '0;
        do_reset();

        // Reset values, sampled while reset is still high
        reset = 1'b1; dmao_n = 1'b0;
        tick();
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_bus_rd", bus_rd, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_mem_ack", mem_ack, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_dma_ptr", dma_ptr, 16'h0900);
        chk("rst_sc", SC, 2'b01);
        cpu_sc = 2'b11; #1;
        chk("rst_sc_follow", SC, 2'b11);
        cpu_sc = 2'b01;

        // Full burst of 8 with ack and rdy always high
        reset = 1'b0; rd_prev = 1'b0; clear_counts();
        for (int i = 0; i < 100 && bds == 0; i++) tick();
        dmao_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("b8_acks", acks, 8);
        for (int i = 0; i < 8 && i < dq.size(); i++)
            chk($sformatf("b8_data%0d", i), dq[i], mem_byte(16'h0900 + 16'(i)));
        chk("b8_ptr", dma_ptr, 16'h0908);
        chk("b8_done", bds, 1);
        chk("b8_sc_cycles", scn, 16);
        chk("b8_hold_off", cpu_hold, 0);
        cpu_sc = 2'b11; #1;
        chk("b8_sc_after", SC, 2'b11);

        // dmao_n withdrawn after the 3rd read strobe
        do_reset();
        dmao_n = 1'b0;
        for (int i = 0; i < 100 && rds < 3; i++) tick();
        chk("s3_rd_seen", rds, 3);
        dmao_n = 1'b1;
        for (int i = 0; i < 100 && bds == 0; i++) tick();
        for (int i = 0; i < 4; i++) tick();
        chk("s3_acks", acks, 3);
        chk("s3_data2", (dq.size() > 2) ? dq[2] : 8'hxx, mem_byte(16'h0902));
        chk("s3_done", bds, 1);
        chk("s3_ptr", dma_ptr, 16'h0903);

        // Pointer wrap across 16'hFFFF
        do_reset();
        load_r0(16'hFFFE);
        chk("wr_ptr_load", dma_ptr, 16'hFFFE);
        dmao_n = 1'b0;
        for (int i = 0; i < 100 && rds < 4; i++) tick();
        dmao_n = 1'b1;
        for (int i = 0; i < 100 && bds == 0; i++) tick();
        chk("wr_acks", acks, 4);
        chk("wr_addr0", (aq.size() > 0) ? aq[0] : 16'hxxxx, 16'hFFFE);
        chk("wr_addr1", (aq.size() > 1) ? aq[1] : 16'hxxxx, 16'hFFFF);
        chk("wr_addr2", (aq.size() > 2) ? aq[2] : 16'hxxxx, 16'h0000);
        chk("wr_addr3", (aq.size() > 3) ? aq[3] : 16'hxxxx, 16'h0001);
        chk("wr_data2", (dq.size() > 2) ? dq[2] : 8'hxx, mem_byte(16'h0000));
        chk("wr_ptr", dma_ptr, 16'h0002);

        // r0_load colliding with the increment of the byte at 0x0905
        do_reset();
        dmao_n = 1'b0;
        for (int i = 0; i < 100 && rds < 6; i++) tick();
        chk("col_rd_addr", (aq.size() > 5) ? aq[5] : 16'hxxxx, 16'h0905);
        r0_load = 1'b1; r0_value = 16'h1234;
        tick();
        r0_load = 1'b0;
        chk("col_ack", acks, 6);
        chk("col_ptr", dma_ptr, 16'h1234);
        for (int i = 0; i < 100 && rds < 7; i++) tick();
        dmao_n = 1'b1;
        chk("col_next_addr", (aq.size() > 6) ? aq[6] : 16'hxxxx, 16'h1234);
        for (int i = 0; i < 100 && bds == 0; i++) tick();
        chk("col_ptr_after", dma_ptr, 16'h1235);

        // Frame reload on the rising edge only, independent of clk_enable
        do_reset();
        load_r0(16'h09A0);
        chk("fr_pre", dma_ptr, 16'h09A0);
        clk_enable = 1'b0;
        frame_int  = 1'b1;
        tick();
        chk("fr_reload", dma_ptr, 16'h0900);
        tick();
        load_r0(16'h4444);
        for (int i = 0; i < 7; i++) tick();
        chk("fr_level_once", dma_ptr, 16'h4444);
        frame_int  = 1'b0;
        clk_enable = 1'b1;
        tick();

        // Request withdrawn in REQ before the CPU acknowledges
        do_reset();
        cpu_hold_ack = 1'b0;
        dmao_n = 1'b0;
        tick();
        chk("rq_hold", cpu_hold, 1);
        tick();
        dmao_n = 1'b1;
        for (int i = 0; i < 20 && bds == 0; i++) tick();
        chk("rq_done", bds, 1);
        chk("rq_acks", acks, 0);
        chk("rq_reads", rds, 0);
        chk("rq_hold_off", cpu_hold, 0);

        // Reset while stalled in DATA with the read strobe up
        do_reset();
        load_r0(16'h2000);
        bus_rdy = 1'b0;
        dmao_n  = 1'b0;
        for (int i = 0; i < 100 && rds < 1; i++) tick();
        tick();
        tick();
        chk("ab_in_data", bus_rd, 1);
        reset   = 1'b1;
        bus_rdy = 1'b1;
        tick();
        chk("ab_bus_rd", bus_rd, 0);
        chk("ab_hold", cpu_hold, 0);
        chk("ab_mem_ack", mem_ack, 0);
        chk("ab_ptr", dma_ptr, 16'h0900);
        reset  = 1'b0;
        dmao_n = 1'b1;
        tick();
        tick();
        chk("ab_idle_hold", cpu_hold, 0);
        chk("ab_idle_sc", SC, cpu_sc);
        chk("ab_no_ack", acks, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
